// File: rtl/lms_ctr_switch_pkg.sv
// lms_ctr_switch_pkg: register map, edge-type encodings and a width helper for the switch controller
package lms_ctr_switch_pkg;
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_RAW  = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/lms_ctr_switch_debounce_bit.sv
// switch_debounce_bit: 2-FF synchroniser plus tick-driven debounce counter for one switch
module switch_debounce_bit
    import lms_ctr_switch_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic pin_i,
    output logic sync_o,
    output logic deb_o
);
    localparam int CW = cw(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS - 1);
    logic [1:0] sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic deb_q, deb_d, mism, done;
    always_comb begin
        mism  = sync_q[1] ^ deb_q;
        done  = tick_i && (cnt_q == CNT_MAX);
        cnt_d = (!mism || done) ? '0 : tick_i ? cnt_q + CW'(1) : cnt_q;
        deb_d = deb_q ^ (mism && done);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end
    assign sync_o = sync_q[1];
    assign deb_o  = deb_q;
endmodule

// File: rtl/lms_ctr_switch_ctrl.sv
// lms_ctr_switch_ctrl: Avalon-MM switch port with debounce, edge capture and maskable irq
module lms_ctr_switch_ctrl
    import lms_ctr_switch_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int EDGE_TYPE      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam int PW = cw(TICK_DIV);
    logic [PW-1:0] pre_q, pre_d;
    logic tick, irq_q, irq_d, unused_wd;
    logic [WIDTH-1:0] sync, deb, deb_p_q, mask_q, mask_d, edge_q, edge_d, rise, fall, evt, w1c;
    logic [31:0] rdata_q, rdata_d;
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            switch_debounce_bit #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_bit (
                .clk   (clk),
                .reset (reset),
                .tick_i(tick),
                .pin_i (in_port[i]),
                .sync_o(sync[i]),
                .deb_o (deb[i])
            );
        end
    endgenerate
    always_comb begin
        tick    = (pre_q == PW'(TICK_DIV - 1));
        pre_d   = tick ? '0 : pre_q + PW'(1);
        rise    = deb & ~deb_p_q;
        fall    = ~deb & deb_p_q;
        evt     = (EDGE_TYPE == EDGE_RISE) ? rise : (EDGE_TYPE == EDGE_FALL) ? fall : rise | fall;
        w1c     = (write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        // a new edge overrides a same-cycle clear so no event is lost
        edge_d  = (edge_q & ~w1c) | evt;
        mask_d  = (write && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
        irq_d   = |(edge_q & mask_q);
        rdata_d = (address == ADDR_DATA) ? 32'(deb) :
                  (address == ADDR_MASK) ? 32'(mask_q) :
                  (address == ADDR_EDGE) ? 32'(edge_q) : 32'(sync);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            deb_p_q <= '0;
            mask_q  <= '0;
            edge_q  <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            pre_q   <= pre_d;
            deb_p_q <= deb;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end
    assign unused_wd = ^writedata;
    assign readdata  = rdata_q;
    assign irq       = irq_q;
endmodule
